// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: N_W-bit dividend by D_W-bit divisor.
// Latency: N_W cycles from accept to out_valid; a zero divisor gives its result one cycle after accept.
// Backpressure: the result is held with out_valid=1 until out_ready; in_ready is high only in IDLE.
module seq_divider #(
  parameter int N_W = 17,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(N_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [N_W-1:0]   n_sr;      // dividend bits still to be consumed, MSB first
  logic [N_W-1:0]   q_sr;      // quotient bits produced so far
  logic [D_W-1:0]   d_r;
  logic [D_W:0]     r;         // partial remainder, one guard bit for the shifted-in bit
  logic [CNT_W-1:0] cnt;

  logic [D_W:0]     t;
  logic             ge;
  logic [D_W:0]     r_nx;
  logic [N_W-1:0]   q_nx;
  logic             accept;
  logic             last;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    t    = {r[D_W-1:0], n_sr[N_W-1]};
    ge   = (t >= {1'b0, d_r});
    r_nx = ge ? (t - {1'b0, d_r}) : t;
    q_nx = {q_sr[N_W-2:0], ge};
    last = (cnt == CNT_LAST);
  end

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working registers and the registered result; results only move on accept or the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_sr      <= '0;
      q_sr      <= '0;
      d_r       <= '0;
      r         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor != '0) begin
              n_sr <= dividend;
              d_r  <= divisor;
              r    <= '0;
              q_sr <= '0;
              cnt  <= '0;
            end else begin
              quotient  <= '1;
              remainder <= dividend[D_W-1:0];
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          n_sr <= {n_sr[N_W-2:0], 1'b0};
          r    <= r_nx;
          q_sr <= q_nx;
          cnt  <= cnt + 1'b1;
          if (last) begin
            quotient  <= q_nx;
            remainder <= r_nx[D_W-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a queue-based scoreboard.
// Stimulus pushes expected results on accept; a negedge monitor compares whenever out_valid is up.
// Checks latency, held outputs under backpressure, in_ready around handshakes, and reset abort.
module tb_seq_divider;

  localparam int N_W = 17;
  localparam int D_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N_W-1:0] dividend;
  logic [D_W-1:0] divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] quotient;
  logic [D_W-1:0] remainder;
  logic           div_zero;

  seq_divider #(.N_W(N_W), .D_W(D_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           dz;
    int             lat;   // clock edges after the accept edge at which out_valid becomes visible
    int             acc;   // edge count at the accept edge
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  bit   ov_prev = 1'b0;
  bit   chk_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: compares the presented result against the head of the scoreboard on every valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (chk_rdy) begin
        chk_rdy = 1'b0;
        chk("in_ready_after_handshake", in_ready, 1);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          e = sb[0];
          if (!ov_prev) chk("latency", cyc - e.acc, e.lat);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_zero", div_zero, e.dz);
          chk("in_ready_while_done", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            chk_rdy = 1'b1;
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  // Present one operation (called just after a negedge) and wait for its accept edge.
  task automatic issue(input logic [N_W-1:0] a, input logic [D_W-1:0] b, input bit push,
                       input logic [N_W-1:0] eq, input logic [D_W-1:0] er, input bit edz);
    exp_t e;
    int   waitc = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.lat = edz ? 0 : N_W;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait until every expected result has been consumed and the block is idle again.
  task automatic drain();
    int waitc = 0;
    while ((sb.size() != 0 || out_valid) && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (sb.size() != 0 || out_valid) chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_div_zero", div_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic division.
    issue(17'd100, 8'd7, 1'b1, 17'd14, 8'd2, 1'b0);
    in_valid = 1'b0;
    drain();

    // Inverse of the multiply-accumulate (200*37+1234) and width extremes.
    issue(17'd8634, 8'd37, 1'b1, 17'd233, 8'd13, 1'b0);
    in_valid = 1'b0;
    drain();
    issue(17'd131071, 8'd1, 1'b1, 17'd131071, 8'd0, 1'b0);
    in_valid = 1'b0;
    drain();
    issue(17'd131071, 8'd255, 1'b1, 17'd514, 8'd1, 1'b0);
    in_valid = 1'b0;
    drain();
    issue(17'd0, 8'd5, 1'b1, 17'd0, 8'd0, 1'b0);
    in_valid = 1'b0;
    drain();

    // Divide by zero: 5000 = 0x1388.
    issue(17'd5000, 8'd0, 1'b1, 17'h1FFFF, 8'h88, 1'b1);
    in_valid = 1'b0;
    drain();

    // Backpressure: result must sit unchanged for 10 cycles.
    out_ready = 1'b0;
    issue(17'd1000, 8'd9, 1'b1, 17'd111, 8'd1, 1'b0);
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("backpressure_valid_seen", out_valid, 1);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a run discards the operation.
    issue(17'd60000, 8'd13, 1'b0, 17'd0, 8'd0, 1'b0);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_zero", div_zero, 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_no_output", out_valid, 0);
    issue(17'd60000, 8'd13, 1'b1, 17'd4615, 8'd5, 1'b0);
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high.
    issue(17'd50, 8'd3, 1'b1, 17'd16, 8'd2, 1'b0);
    issue(17'd255, 8'd255, 1'b1, 17'd1, 8'd0, 1'b0);
    issue(17'd7, 8'd8, 1'b1, 17'd0, 8'd7, 1'b0);
    in_valid = 1'b0;
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring divider; the inverse of the combinational multiply-accumulate datapath (RES = A*B + M).
- Takes a 17-bit dividend (a multiplier result width) and an 8-bit divisor, and returns quotient and remainder.
- Processes one quotient bit per clock.
- Uses a valid/ready handshake on both input and output, so it can sit behind the multiplier in the arithmetic pipeline.

Parameters:
- N_W, 17, dividend and quotient width
- D_W, 8, divisor and remainder width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operation
- dividend  input  N_W  numerator, unsigned
- divisor  input  D_W  denominator, unsigned
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- quotient  output  N_W  floor(dividend/divisor)
- remainder  output  D_W  dividend mod divisor
- div_zero  output  1  the operation had divisor == 0

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_zero=0.
  - Internal counter and working registers cleared.
  - Reset overrides everything, including mid-RUN or DONE; any in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1. Accept occurs on an edge with in_valid && in_ready.
    - divisor != 0: latch dividend into shift register n_sr, latch divisor into d_r, clear partial remainder r (D_W+1 bits), clear quotient and cnt, go to RUN.
    - divisor == 0: quotient = all ones, remainder = dividend[D_W-1:0], div_zero=1, go to DONE.
  - RUN: in_ready=0, out_valid=0. Each edge performs one step:
    - t = {r[D_W-1:0], n_sr[N_W-1]}; n_sr shifts left by 1.
    - If t >= {1'b0,d_r}: r = t - d_r, shift 1 into the quotient LSB. Otherwise r = t, shift 0.
    - cnt increments.
    - On the edge where cnt == N_W-1: step is performed, remainder = r_next[D_W-1:0], div_zero=0, go to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs held stable while out_ready=0. On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency:
  - out_valid rises exactly N_W cycles after the accept edge (17 by default).
  - Divisor zero: 1 cycle.
  - Throughput is one operation per N_W+2 cycles minimum: accept, N_W steps, handshake.
- No same-cycle accept in DONE. A new accept is possible only in IDLE, i.e. the cycle after the output handshake.
- in_valid during RUN/DONE is ignored; the producer must hold it until in_ready.
- Width rules:
  - Remainder is always < divisor, so D_W bits suffice.
  - The compare/subtract uses D_W+1 bits so the shifted-in bit never overflows.
- Boundary cases:
  - Dividend 0 → quotient 0, remainder 0, full N_W latency.
  - Dividend < divisor → quotient 0, remainder = dividend.
  - Divisor 1 → quotient = dividend, remainder 0.
- quotient, remainder and div_zero are registered and change only on the accept edge (div-zero case) or the final RUN edge; they hold after the handshake until the next result.

Test Plan:
- Reset, then dividend=100, divisor=7, out_ready=1 → out_valid exactly 17 cycles after accept; quotient=14, remainder=2, div_zero=0; in_ready returns 1 one cycle after the handshake.
- Inverse check of the multiplier: A=200, B=37, M=1234 gives RES=8634; divide 8634/37 → quotient=233, remainder=13. Also 131071/1 → 131071 r 0, and 131071/255 → 514 r 1.
- Divisor=0, dividend=5000 → out_valid 1 cycle after accept; quotient=17'h1FFFF, remainder=8'h88, div_zero=1.
- Backpressure: 1000/9 with out_ready=0 for 10 cycles after out_valid → quotient=111 and remainder=1 held stable with out_valid=1; in_ready=0 throughout; a single handshake on out_ready=1.
- Reset mid-operation: assert rst at cycle 8 of RUN for 60000/13 → next cycle state is IDLE, out_valid=0, outputs 0, in_ready=1. A fresh 60000/13 → 4615 r 5.
- Back-to-back: in_valid held high across three operands (50/3, 255/255, 7/8) → results 16 r 2, 1 r 0, 0 r 7 in order, each at N_W-cycle latency, none dropped or duplicated.
